counter_loop_nested: RTL and testbench

//  Two-level programmable loop counter (inner/outer) for MFCC iteration control,
//  e.g. FFT bin within filter bank, filter within frame. Generalises the single

---
 rtl/counter_loop_nested.sv | 126 ++++++++++++
 tb/tb_counter_loop_nested.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_loop_nested.sv
// Two-level (outer/inner) programmable loop counter with start/busy/done handshake and clear.
// Optional inner stride port enabled by defining COUNTER_LOOP_STEP_EN.
module counter_loop_nested #(
  parameter int INNER_W = 8,
  parameter int OUTER_W = 8,
  parameter int STEP_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clear,
  input  logic               cnt_en,
  input  logic [INNER_W-1:0] inner_max,
  input  logic [OUTER_W-1:0] outer_max,
`ifdef COUNTER_LOOP_STEP_EN
  input  logic [STEP_W-1:0]  inner_step,
`endif
  output logic [INNER_W-1:0] inner_cnt,
  output logic [OUTER_W-1:0] outer_cnt,
  output logic               inner_last,
  output logic               outer_last,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // One spare bit so inner index + stride never wraps before the compare.
  localparam int SUM_W = ((STEP_W > INNER_W) ? STEP_W : INNER_W) + 1;

  logic [1:0]         state_q, state_d;
  logic [INNER_W-1:0] inner_cnt_q, inner_cnt_d;
  logic [OUTER_W-1:0] outer_cnt_q, outer_cnt_d;
  logic [INNER_W-1:0] inner_max_l_q, inner_max_l_d;
  logic [OUTER_W-1:0] outer_max_l_q, outer_max_l_d;
  logic [STEP_W-1:0]  step_l;
  logic [SUM_W-1:0]   sum;
  logic               row_end;

`ifdef COUNTER_LOOP_STEP_EN
  logic [STEP_W-1:0]  step_q, step_d;

  always_comb begin
    step_d = step_q;
    if (state_q == S_IDLE && start && !clear)
      step_d = (inner_step == '0) ? STEP_W'(1) : inner_step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= '0;
    else        step_q <= step_d;
  end

  assign step_l = step_q;
`else
  assign step_l = STEP_W'(1);
`endif

  assign sum     = SUM_W'(inner_cnt_q) + SUM_W'(step_l);
  assign row_end = (sum > SUM_W'(inner_max_l_q));

  always_comb begin
    state_d       = state_q;
    inner_cnt_d   = inner_cnt_q;
    outer_cnt_d   = outer_cnt_q;
    inner_max_l_d = inner_max_l_q;
    outer_max_l_d = outer_max_l_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          inner_max_l_d = inner_max;
          outer_max_l_d = outer_max;
          inner_cnt_d   = '0;
          outer_cnt_d   = '0;
          state_d       = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_en) begin
          if (!row_end) begin
            inner_cnt_d = sum[INNER_W-1:0];
          end else if (outer_cnt_q != outer_max_l_q) begin
            inner_cnt_d = '0;
            outer_cnt_d = outer_cnt_q + OUTER_W'(1);
          end else begin
            // Final index consumed: counters keep it until the next start.
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d     = S_IDLE;
      inner_cnt_d = '0;
      outer_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      inner_cnt_q   <= '0;
      outer_cnt_q   <= '0;
      inner_max_l_q <= '0;
      outer_max_l_q <= '0;
    end else begin
      state_q       <= state_d;
      inner_cnt_q   <= inner_cnt_d;
      outer_cnt_q   <= outer_cnt_d;
      inner_max_l_q <= inner_max_l_d;
      outer_max_l_q <= outer_max_l_d;
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign inner_cnt  = inner_cnt_q;
  assign outer_cnt  = outer_cnt_q;
  assign inner_last = busy & row_end;
  assign outer_last = busy & (outer_cnt_q == outer_max_l_q);

endmodule

// File: tb/tb_counter_loop_nested.sv
// Randomized bench for counter_loop_nested against a nested-for-loop index model.
module tb_counter_loop_nested;
  localparam int INNER_W = 8;
  localparam int OUTER_W = 8;
  localparam int STEP_W  = 4;

  logic               clk = 1'b0;
  logic               rst_n, start, clear, cnt_en;
  logic [INNER_W-1:0] inner_max;
  logic [OUTER_W-1:0] outer_max;
`ifdef COUNTER_LOOP_STEP_EN
  logic [STEP_W-1:0]  inner_step;
`endif
  logic [INNER_W-1:0] inner_cnt;
  logic [OUTER_W-1:0] outer_cnt;
  logic               inner_last, outer_last, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  counter_loop_nested #(.INNER_W(INNER_W), .OUTER_W(OUTER_W), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .cnt_en(cnt_en),
    .inner_max(inner_max), .outer_max(outer_max),
`ifdef COUNTER_LOOP_STEP_EN
    .inner_step(inner_step),
`endif
    .inner_cnt(inner_cnt), .outer_cnt(outer_cnt), .inner_last(inner_last),
    .outer_last(outer_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_step(input int s);
`ifdef COUNTER_LOOP_STEP_EN
    inner_step = STEP_W'(s);
`else
    if (s != 1) $display("note: stride ignored in this build");
`endif
  endtask

  // Start a run, feed cnt_en randomly, and check every visible index against the model.
  task automatic run_loop(input int imax, input int omax, input int stp,
                          input int en_pct, input bit poke_start, output int beats);
    int ei[$];
    int eo[$];
    int s, idx, cyc, limit, fi, fo;
    bit en;
    s = (stp == 0) ? 1 : stp;
    for (int o = 0; o <= omax; o++)
      for (int i = 0; i <= imax; i += s) begin
        ei.push_back(i);
        eo.push_back(o);
      end
    inner_max = INNER_W'(imax);
    outer_max = OUTER_W'(omax);
    set_step(stp);
    start = 1'b1; cnt_en = 1'b0;
    tick();
    start = 1'b0;
    idx = 0; cyc = 0; beats = 0;
    limit = ei.size() * 10 + 100;
    while (idx < ei.size() && cyc < limit) begin
      en = ($urandom_range(99) < en_pct);
      cnt_en = en;
      if (poke_start) begin
        start     = ($urandom_range(3) == 0);
        inner_max = INNER_W'($urandom);
        outer_max = OUTER_W'($urandom);
      end
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0 ||
          inner_cnt !== INNER_W'(ei[idx]) || outer_cnt !== OUTER_W'(eo[idx]) ||
          inner_last !== ((ei[idx] + s) > imax) || outer_last !== (eo[idx] == omax)) begin
        n_fail++;
        $display("FAIL beat%0d: got busy=%b done=%b idx=(%0d,%0d) il=%b ol=%b, required busy=1 done=0 idx=(%0d,%0d) il=%b ol=%b",
                 idx, busy, done, outer_cnt, inner_cnt, inner_last, outer_last,
                 eo[idx], ei[idx], ((ei[idx] + s) > imax), (eo[idx] == omax));
      end
      tick();
      if (en) begin idx++; beats++; end
      cyc++;
    end
    start = 1'b0; cnt_en = 1'b0;
    n_checks++;
    if (idx < ei.size()) begin
      n_fail++;
      $display("FAIL run_timeout: got %0d beats consumed, required %0d", idx, ei.size());
    end
    fi = ei[ei.size()-1];
    fo = eo[eo.size()-1];
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || inner_cnt !== INNER_W'(fi) || outer_cnt !== OUTER_W'(fo)) begin
      n_fail++;
      $display("FAIL done_pulse: got done=%b busy=%b idx=(%0d,%0d), required done=1 busy=0 idx=(%0d,%0d)",
               done, busy, outer_cnt, inner_cnt, fo, fi);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || inner_cnt !== INNER_W'(fi) || outer_cnt !== OUTER_W'(fo)) begin
      n_fail++;
      $display("FAIL after_done: got done=%b busy=%b idx=(%0d,%0d), required done=0 busy=0 idx=(%0d,%0d)",
               done, busy, outer_cnt, inner_cnt, fo, fi);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; cnt_en = 1'b0;
    inner_max = '0; outer_max = '0;
    set_step(1);
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || inner_cnt !== '0 || outer_cnt !== '0 ||
        inner_last !== 1'b0 || outer_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got busy=%b done=%b idx=(%0d,%0d) il=%b ol=%b, required all zero",
               busy, done, outer_cnt, inner_cnt, inner_last, outer_last);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int b;
    run_loop(3, 2, 1, 100, 1'b0, b);
    n_checks++;
    if (b != 12) begin
      n_fail++;
      $display("FAIL basic_beats: got %0d, required 12", b);
    end
  endtask

  task automatic test_degenerate();
    int b;
    run_loop(0, 0, 1, 100, 1'b0, b);
    n_checks++;
    if (b != 1) begin
      n_fail++;
      $display("FAIL degenerate_beats: got %0d, required 1", b);
    end
  endtask

  task automatic test_full_range();
    int b;
    run_loop(255, 1, 1, 100, 1'b0, b);
    n_checks++;
    if (b != 512) begin
      n_fail++;
      $display("FAIL full_range_beats: got %0d, required 512", b);
    end
  endtask

  task automatic test_start_ignored();
    int b;
    run_loop(4, 3, 1, 50, 1'b1, b);
    n_checks++;
    if (b != 20) begin
      n_fail++;
      $display("FAIL start_ignored_beats: got %0d, required 20", b);
    end
  endtask

  task automatic test_random();
    int b, im, om, st;
    for (int r = 0; r < 10; r++) begin
      im = $urandom_range(15);
      om = $urandom_range(7);
`ifdef COUNTER_LOOP_STEP_EN
      st = $urandom_range(4);
`else
      st = 1;
`endif
      run_loop(im, om, st, 60, r[0], b);
      repeat ($urandom_range(2)) tick();
    end
  endtask

`ifdef COUNTER_LOOP_STEP_EN
  task automatic test_step();
    int b;
    run_loop(7, 1, 3, 100, 1'b0, b);
    n_checks++;
    if (b != 6) begin
      n_fail++;
      $display("FAIL step3_beats: got %0d, required 6", b);
    end
    run_loop(3, 1, 0, 100, 1'b0, b);
    n_checks++;
    if (b != 8) begin
      n_fail++;
      $display("FAIL step0_beats: got %0d, required 8", b);
    end
  endtask
`endif

  task automatic test_clear();
    inner_max = 8'd3; outer_max = 8'd2;
    set_step(1);
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || inner_cnt !== '0 || outer_cnt !== '0) begin
      n_fail++;
      $display("FAIL clear_with_start: got busy=%b done=%b idx=(%0d,%0d), required idle zeros",
               busy, done, outer_cnt, inner_cnt);
    end
    start = 1'b1;
    tick();
    start = 1'b0; cnt_en = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (busy !== 1'b1 || inner_cnt !== 8'd1 || outer_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL pre_clear: got busy=%b idx=(%0d,%0d), required busy=1 idx=(1,1)",
               busy, outer_cnt, inner_cnt);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0; cnt_en = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || inner_cnt !== '0 || outer_cnt !== '0) begin
      n_fail++;
      $display("FAIL clear_mid_run: got busy=%b done=%b idx=(%0d,%0d), required idle zeros",
               busy, done, outer_cnt, inner_cnt);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_no_done: got done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_async_reset();
    inner_max = 8'd5; outer_max = 8'd4;
    set_step(1);
    start = 1'b1;
    tick();
    start = 1'b0; cnt_en = 1'b1;
    repeat (8) tick();
    cnt_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || inner_cnt !== '0 || outer_cnt !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b done=%b idx=(%0d,%0d), required reset values",
               busy, done, outer_cnt, inner_cnt);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL after_async_reset: got busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_degenerate();
    test_full_range();
    test_start_ignored();
    test_random();
`ifdef COUNTER_LOOP_STEP_EN
    test_step();
`endif
    test_clear();
    test_async_reset();
    test_basic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
